// File: rtl/lcd_pkg.sv
// lcd_pkg: opcode bounds, nibble-phase type and the space character shared by lcd_responder.
package lcd_pkg;
  typedef enum logic [1:0] {MODE8, HI, LO} phase_e;
  localparam logic [7:0] SPACE      = 8'h20;
  localparam logic [7:0] OP_CLEAR   = 8'h01;
  localparam logic [7:0] OP_HOME    = 8'h02;
  localparam logic [7:0] OP_ENTRY   = 8'h04;
  localparam logic [7:0] OP_DISPLAY = 8'h08;
  localparam logic [7:0] OP_SHIFT   = 8'h10;
  localparam logic [7:0] OP_FUNC    = 8'h20;
  localparam logic [7:0] OP_CGRAM   = 8'h40;
  localparam logic [7:0] OP_DDRAM   = 8'h80;
endpackage

// File: rtl/lcd_responder_if.sv
// lcd_responder_if: host strobe/nibble bus, DDRAM read port and status; trace
// signals exist only when LCD_RESPONDER_TRACE_EN is defined.
interface lcd_responder_if #(parameter int COLS = 16) ();
  localparam int AW = $clog2(COLS) + 1;
  logic          lcd_en;
  logic          lcd_rs;
  logic [3:0]    lcd_data;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic [6:0]    cursor_addr;
  logic          four_bit;
  logic          display_on;
  logic          busy;
  logic          overrun;
`ifdef LCD_RESPONDER_TRACE_EN
  logic          trace_valid;
  logic          trace_rs;
  logic [7:0]    trace_byte;
`endif
  modport master (
`ifdef LCD_RESPONDER_TRACE_EN
    input trace_valid, trace_rs, trace_byte,
`endif
    output lcd_en, lcd_rs, lcd_data, rd_addr,
    input rd_data, cursor_addr, four_bit, display_on, busy, overrun
  );
  modport slave (
`ifdef LCD_RESPONDER_TRACE_EN
    output trace_valid, trace_rs, trace_byte,
`endif
    input lcd_en, lcd_rs, lcd_data, rd_addr,
    output rd_data, cursor_addr, four_bit, display_on, busy, overrun
  );
endinterface

// File: rtl/lcd_ddram.sv
// lcd_ddram: 2*COLS x 8 display RAM, one write port, registered read port.
module lcd_ddram #(
  parameter int COLS = 16,
  parameter int AW   = $clog2(COLS) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem_q [2*COLS];
  logic [7:0] rdata_q;
  always_ff @(posedge clk) if (we) mem_q[waddr] <= wdata;
  always_ff @(posedge clk or negedge reset)
    if (!reset) rdata_q <= '0;
    else rdata_q <= mem_q[raddr];
  assign rdata = rdata_q;
endmodule

// File: rtl/lcd_responder.sv
// lcd_responder: HD44780-style responder decoding 8/4-bit host strobes into a 2-row DDRAM.
// Define LCD_RESPONDER_TRACE_EN to add the executed-byte trace outputs.
module lcd_responder
  import lcd_pkg::*;
#(parameter int COLS = 16) (
  input logic            clk,
  input logic            reset,
  lcd_responder_if.slave bus
);
  localparam int LW = $clog2(COLS);
  localparam int AW = LW + 1;
  localparam logic [AW-1:0] LAST   = AW'(2 * COLS - 1);
  localparam logic [6:0]    R0_END = 7'(COLS - 1);
  localparam logic [6:0]    R1_END = 7'(64 + COLS - 1);
  phase_e phase_q, phase_d;
  logic en_q, rs_cap_q, rs_cap_d, four_bit_q, four_bit_d, disp_q, disp_d, id_q, id_d;
  logic busy_q, busy_d, ovr_q, ovr_d, strobe, exec, we;
  logic [3:0] nib_q, nib_d, hi_q, hi_d;
  logic [6:0] ac_q, ac_d, ac_step;
  logic [AW-1:0] clr_q, clr_d, waddr;
  logic [7:0] byte_v, wdata, rd_data;
  assign strobe  = en_q & ~bus.lcd_en;
  assign ac_step = id_q ? (ac_q == R0_END ? 7'h40 : ac_q == R1_END ? 7'h00 : ac_q + 7'd1)
                        : (ac_q == 7'h00 ? R1_END : ac_q == 7'h40 ? R0_END : ac_q - 7'd1);
  always_comb begin
    rs_cap_d   = bus.lcd_en ? bus.lcd_rs : rs_cap_q;
    nib_d      = bus.lcd_en ? bus.lcd_data : nib_q;
    phase_d    = phase_q;
    hi_d       = hi_q;
    four_bit_d = four_bit_q;
    disp_d     = disp_q;
    id_d       = id_q;
    ac_d       = ac_q;
    busy_d     = busy_q;
    clr_d      = busy_q ? clr_q + 1'b1 : clr_q;
    ovr_d      = ovr_q | (strobe & busy_q);
    exec       = 1'b0;
    byte_v     = phase_q == LO ? {hi_q, nib_q} : {nib_q, 4'h0};
    we         = busy_q;
    waddr      = clr_q;
    wdata      = SPACE;
    if (busy_q && clr_q == LAST) busy_d = 1'b0;
    if (strobe && !busy_q) begin
      exec    = phase_q != HI;
      hi_d    = phase_q == HI ? nib_q : hi_q;
      phase_d = phase_q == HI ? LO : phase_q == LO ? HI : MODE8;
    end
    if (exec && rs_cap_q) begin
      we    = 1'b1;
      waddr = {ac_q[6], ac_q[LW-1:0]};
      wdata = byte_v;
      ac_d  = ac_step;
    end else if (exec) begin
      if (byte_v >= OP_DDRAM) ac_d = byte_v[6:0];
      else if (byte_v >= OP_FUNC && byte_v < OP_CGRAM) begin
        four_bit_d = ~byte_v[4];
        phase_d    = byte_v[4] ? MODE8 : HI;
      end
      else if (byte_v >= OP_DISPLAY && byte_v < OP_SHIFT) disp_d = byte_v[2];
      else if (byte_v >= OP_ENTRY && byte_v < OP_DISPLAY) id_d = byte_v[1];
      else if (byte_v >= OP_HOME && byte_v < OP_ENTRY) ac_d = 7'h00;
      else if (byte_v == OP_CLEAR) begin
        ac_d   = 7'h00;
        id_d   = 1'b1;
        busy_d = 1'b1;
        clr_d  = '0;
      end
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      phase_q    <= MODE8;
      en_q       <= 1'b0;
      rs_cap_q   <= 1'b0;
      nib_q      <= '0;
      hi_q       <= '0;
      four_bit_q <= 1'b0;
      disp_q     <= 1'b0;
      id_q       <= 1'b1;
      ac_q       <= '0;
      busy_q     <= 1'b0;
      clr_q      <= '0;
      ovr_q      <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      en_q       <= bus.lcd_en;
      rs_cap_q   <= rs_cap_d;
      nib_q      <= nib_d;
      hi_q       <= hi_d;
      four_bit_q <= four_bit_d;
      disp_q     <= disp_d;
      id_q       <= id_d;
      ac_q       <= ac_d;
      busy_q     <= busy_d;
      clr_q      <= clr_d;
      ovr_q      <= ovr_d;
    end
  lcd_ddram #(.COLS(COLS), .AW(AW)) u_ddram (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(bus.rd_addr), .rdata(rd_data)
  );
  assign bus.rd_data     = rd_data;
  assign bus.cursor_addr = ac_q;
  assign bus.four_bit    = four_bit_q;
  assign bus.display_on  = disp_q;
  assign bus.busy        = busy_q;
  assign bus.overrun     = ovr_q;
`ifdef LCD_RESPONDER_TRACE_EN
  logic tv_q, trs_q, trs_d;
  logic [7:0] tb_q, tb_d;
  always_comb begin
    trs_d = exec ? rs_cap_q : trs_q;
    tb_d  = exec ? byte_v : tb_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      tv_q  <= 1'b0;
      trs_q <= 1'b0;
      tb_q  <= '0;
    end else begin
      tv_q  <= exec;
      trs_q <= trs_d;
      tb_q  <= tb_d;
    end
  assign bus.trace_valid = tv_q;
  assign bus.trace_rs    = trs_q;
  assign bus.trace_byte  = tb_q;
`endif
endmodule

// File: tb/tb_lcd_responder.sv
// tb_lcd_responder: directed strobes against a row/column model of the LCD controller.
module tb_lcd_responder;
  localparam int COLS = 16;
  localparam int AW   = $clog2(COLS) + 1;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  lcd_responder_if #(.COLS(COLS)) bus ();
  lcd_responder #(.COLS(COLS)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  int n_chk = 0, n_fail = 0, cyc = 0, clr_at = -1000, m_phase = 0;
  bit chk_on = 0, m_four, m_disp, m_id, m_ovr;
  logic [6:0] m_ac;
  logic [3:0] m_hi;
  logic [7:0] m_mem [2*COLS];
  bit m_known [2*COLS];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  always @(posedge clk) cyc++;
  // Continuous status comparison against the model.
  always @(negedge clk) if (chk_on) begin
    chk("four_bit", bus.four_bit, m_four);
    chk("display_on", bus.display_on, m_disp);
    chk("cursor_addr", bus.cursor_addr, m_ac);
    chk("overrun", bus.overrun, m_ovr);
    chk("busy", bus.busy, cyc >= clr_at && cyc - clr_at < 2 * COLS);
  end
  function automatic int m_idx(input logic [6:0] a);
    return (a >= 7'h40 ? COLS : 0) + int'(a) % COLS;
  endfunction
  function automatic logic [6:0] m_step(input logic [6:0] a, input bit inc);
    int row = a >= 7'h40;
    int col = int'(a) % COLS;
    if (inc) return col == COLS - 1 ? (row ? 7'h00 : 7'h40) : a + 7'd1;
    return col == 0 ? (row ? 7'(COLS - 1) : 7'(64 + COLS - 1)) : a - 7'd1;
  endfunction
  task automatic m_exec(input bit rs, input logic [7:0] b);
    if (rs) begin
      m_mem[m_idx(m_ac)] = b;
      m_known[m_idx(m_ac)] = 1;
      m_ac = m_step(m_ac, m_id);
    end
    else if (b >= 8'h80) m_ac = b[6:0];
    else if (b >= 8'h40) ;
    else if (b >= 8'h20) begin m_four = !b[4]; m_phase = b[4] ? 0 : 1; end
    else if (b >= 8'h10) ;
    else if (b >= 8'h08) m_disp = b[2];
    else if (b >= 8'h04) m_id = b[1];
    else if (b >= 8'h02) m_ac = 0;
    else if (b == 8'h01) begin
      m_ac = 0; m_id = 1; clr_at = cyc;
      for (int i = 0; i < 2 * COLS; i++) begin m_mem[i] = 8'h20; m_known[i] = 1; end
    end
  endtask
  task automatic strobe(input bit rs, input logic [3:0] d);
    bus.lcd_en = 1; bus.lcd_rs = rs; bus.lcd_data = d;
    @(posedge clk); #1;
    bus.lcd_en = 0; bus.lcd_rs = !rs; bus.lcd_data = ~d;
    @(posedge clk); #1;
    if (cyc - 1 >= clr_at && cyc - 1 - clr_at < 2 * COLS) m_ovr = 1;
    else if (m_phase == 0) m_exec(rs, {d, 4'h0});
    else if (m_phase == 1) begin m_hi = d; m_phase = 2; end
    else begin m_phase = 1; m_exec(rs, {m_hi, d}); end
  endtask
  task automatic send(input bit rs, input logic [7:0] b);
    strobe(rs, b[7:4]);
    if (m_four) strobe(rs, b[3:0]);
  endtask
  task automatic rd(input int i, input logic [7:0] exp, input string nm);
    bus.rd_addr = AW'(i);
    @(posedge clk); #1;
    chk(nm, bus.rd_data, exp);
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 100 && bus.busy; i++) begin @(posedge clk); #1; end
    chk("clear_timeout", bus.busy, 0);
  endtask
  task automatic do_reset();
    chk_on = 0; reset = 0;
    bus.lcd_en = 0; bus.lcd_rs = 0; bus.lcd_data = 0; bus.rd_addr = 0;
    repeat (2) @(posedge clk); #1;
    chk("rst_four_bit", bus.four_bit, 0);
    chk("rst_display_on", bus.display_on, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_overrun", bus.overrun, 0);
    chk("rst_cursor", bus.cursor_addr, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    m_phase = 0; m_four = 0; m_disp = 0; m_id = 1; m_ovr = 0; m_ac = 0; m_hi = 0; clr_at = -1000;
    for (int i = 0; i < 2 * COLS; i++) m_known[i] = 0;
    reset = 1;
    @(posedge clk); #1;
    chk_on = 1;
  endtask
  task automatic init_seq(output int busy_n);
    strobe(0, 4'h3); strobe(0, 4'h3); strobe(0, 4'h3); strobe(0, 4'h2);
    send(0, 8'h28); send(0, 8'h0C); send(0, 8'h06); send(0, 8'h01);
    busy_n = 0;
    repeat (40) begin @(negedge clk); if (bus.busy) busy_n++; end
    @(posedge clk); #1;
  endtask
  task automatic check_mem(input string nm);
    for (int i = 0; i < 2 * COLS; i++) if (m_known[i]) rd(i, m_mem[i], nm);
  endtask
`ifdef LCD_RESPONDER_TRACE_EN
  int tv_n = 0;
  logic [7:0] tv_b;
  logic tv_rs;
  always @(negedge clk) if (bus.trace_valid) begin tv_n++; tv_b = bus.trace_byte; tv_rs = bus.trace_rs; end
`endif
  initial begin
    int bn;
    do_reset();
    init_seq(bn);
    chk("init_busy_cycles", bn, 32);
    chk("init_four_bit", bus.four_bit, 1);
    chk("init_display_on", bus.display_on, 1);
    chk("init_cursor", bus.cursor_addr, 7'h00);
    for (int i = 0; i < 2 * COLS; i++) rd(i, 8'h20, "init_space");
    send(0, 8'hCB); send(1, 8'h31); send(1, 8'h32);
    chk("row1_cursor", bus.cursor_addr, 7'h4D);
    rd(27, 8'h31, "row1_idx27");
    rd(28, 8'h32, "row1_idx28");
    send(0, 8'h8F); send(1, 8'h41); send(1, 8'h42);
    chk("wrap_inc_cursor", bus.cursor_addr, 7'h41);
    rd(15, 8'h41, "wrap_idx15");
    rd(16, 8'h42, "wrap_idx16");
    send(0, 8'h04); send(0, 8'h80); send(1, 8'h43);
    chk("wrap_dec_cursor", bus.cursor_addr, 7'h4F);
    rd(0, 8'h43, "dec_idx0");
    send(0, 8'hC0); send(1, 8'h45);
    chk("wrap_dec40_cursor", bus.cursor_addr, 7'h0F);
    rd(16, 8'h45, "dec_idx16");
    send(0, 8'h06); send(0, 8'h03); send(0, 8'h1C); send(0, 8'h08);
    chk("home_cursor", bus.cursor_addr, 7'h00);
    chk("display_off", bus.display_on, 0);
    check_mem("model_mem");
    send(0, 8'h0C);
    send(0, 8'h01);
    strobe(1, 4'h5); strobe(1, 4'h5);
    chk("overrun_set", bus.overrun, 1);
    rd(0, 8'h20, "midclear_idx0");
    chk("midclear_busy", bus.busy, 1);
    wait_idle();
    send(0, 8'h80); send(1, 8'h61);
    rd(0, 8'h61, "after_ovr_idx0");
    chk("after_ovr_cursor", bus.cursor_addr, 7'h01);
    chk("overrun_sticky", bus.overrun, 1);
    check_mem("no_0x55");
    strobe(0, 4'h4);
    do_reset();
    init_seq(bn);
    chk("reinit_busy_cycles", bn, 32);
    chk("reinit_four_bit", bus.four_bit, 1);
    chk("reinit_cursor", bus.cursor_addr, 7'h00);
    check_mem("reinit_mem");
    send(1, 8'h41);
    rd(0, 8'h41, "reinit_idx0");
    rd(1, 8'h20, "reinit_idx1");
    send(0, 8'h30);
    chk("mode8_four_bit", bus.four_bit, 0);
    strobe(1, 4'h7);
    rd(1, 8'h70, "mode8_idx1");
    chk("mode8_cursor", bus.cursor_addr, 7'h02);
`ifdef LCD_RESPONDER_TRACE_EN
    begin
      int n0;
      send(0, 8'h20);
      repeat (2) @(posedge clk); #1;
      n0 = tv_n;
      send(0, 8'h0C);
      repeat (3) @(posedge clk); #1;
      chk("trace_pulses", tv_n - n0, 1);
      chk("trace_rs", tv_rs, 0);
      chk("trace_byte", tv_b, 8'h0C);
    end
`endif
    repeat (2) @(posedge clk);
    chk_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
